hyperbus_native_ram: RTL

HYPERBUS_NATIVE_RAM -- requirements
Module: hyperbus_native_ram

---
 rtl/hyperbus_native_ram.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/hyperbus_native_ram.sv
// hyperbus_native_ram
// Responder end of the hyperbus native memory interface, backed by an
// internal word-addressed RAM of 2^MEM_ALOG2 entries. A request held in IDLE
// is accepted and followed by a fixed initial latency. Data beats then
// alternate with gap cycles for as long as the requester keeps its request
// asserted. A fixed recovery period follows before the next request is
// accepted.

module hyperbus_native_ram #(
    parameter int HBUS_ADDR_WIDTH = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int MEM_ALOG2       = 10,
    parameter int INITIAL_LATENCY = 6,
    parameter int RECOVERY        = 2
) (
    input  logic                       hbus_clk,
    input  logic                       hbus_rst,
    input  logic [HBUS_ADDR_WIDTH-1:0] hbus_adr_i,
    input  logic [HBUS_DATA_WIDTH-1:0] hbus_dat_i,
    output logic [HBUS_DATA_WIDTH-1:0] hbus_dat_o,
    input  logic                       hbus_rrq,
    input  logic                       hbus_wrq,
    output logic                       hbus_ready,
    output logic                       hbus_valid,
    output logic                       hbus_busy
);

    localparam int MEM_DEPTH = 1 << MEM_ALOG2;

    // Counters count down to zero, so they are loaded with (length - 1).
    localparam logic [7:0] LAT_LOAD = 8'(INITIAL_LATENCY - 1);
    localparam logic [7:0] REC_LOAD = 8'(RECOVERY - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LATENCY,
        ST_READ,
        ST_WRITE,
        ST_RECOVER
    } state_t;

    state_t                     state;
    logic                       op_read;   // operation latched at acceptance
    logic [MEM_ALOG2-1:0]       ptr;       // current word pointer, wraps naturally
    logic [7:0]                 cnt;       // latency / recovery down-counter
    logic                       beat;      // 1 in a beat cycle, 0 in a gap cycle
    logic                       req_held;  // the request line that keeps this burst alive
    logic                       mem_we;
    logic [HBUS_DATA_WIDTH-1:0] mem [MEM_DEPTH];

    // Only the request matching the accepted operation can extend or end
    // the burst; the other line is ignored once a burst has started.
    assign req_held = op_read ? hbus_rrq : hbus_wrq;

    // A write commits at the edge that closes a write beat cycle. After a
    // reset the state is IDLE, so an aborted burst never reaches memory.
    assign mem_we = (state == ST_WRITE) && beat;

    // Address bits above the memory depth take no part in addressing.
    generate
        if (HBUS_ADDR_WIDTH > MEM_ALOG2) begin : g_upper_adr
            logic unused_upper_adr;
            assign unused_upper_adr = ^hbus_adr_i[HBUS_ADDR_WIDTH-1:MEM_ALOG2];
        end
    endgenerate

    // Memory write port; contents deliberately survive reset.
    always_ff @(posedge hbus_clk) begin
        if (mem_we) begin
            mem[ptr] <= hbus_dat_i;
        end
    end

    // Transaction sequencer with registered beat strobes, busy and read data.
    always_ff @(posedge hbus_clk or posedge hbus_rst) begin
        if (hbus_rst) begin
            state      <= ST_IDLE;
            op_read    <= 1'b0;
            ptr        <= '0;
            cnt        <= '0;
            beat       <= 1'b0;
            hbus_ready <= 1'b0;
            hbus_valid <= 1'b0;
            hbus_busy  <= 1'b0;
            hbus_dat_o <= '0;
        end else begin
            // Strobes are single-cycle pulses unless re-armed below.
            hbus_ready <= 1'b0;
            hbus_valid <= 1'b0;

            case (state)
                ST_IDLE: begin
                    hbus_busy <= 1'b0;
                    if (hbus_rrq || hbus_wrq) begin
                        // A read wins when both requests are present.
                        op_read   <= hbus_rrq;
                        ptr       <= hbus_adr_i[MEM_ALOG2-1:0];
                        cnt       <= LAT_LOAD;
                        beat      <= 1'b0;
                        hbus_busy <= 1'b1;
                        state     <= ST_LATENCY;
                    end
                end

                ST_LATENCY: begin
                    if (!req_held) begin
                        // Requester withdrew before the first beat.
                        cnt   <= REC_LOAD;
                        state <= ST_RECOVER;
                    end else if (cnt == 8'd0) begin
                        // Latency elapsed: issue the first beat now.
                        beat <= 1'b1;
                        if (op_read) begin
                            hbus_valid <= 1'b1;
                            hbus_dat_o <= mem[ptr];
                            state      <= ST_READ;
                        end else begin
                            hbus_ready <= 1'b1;
                            state      <= ST_WRITE;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                ST_READ, ST_WRITE: begin
                    if (beat) begin
                        // Closing a beat: the request is not re-checked here,
                        // the pointer simply advances into the gap cycle.
                        beat <= 1'b0;
                        ptr  <= ptr + 1'b1;
                    end else if (!req_held) begin
                        // Closing a gap with the request dropped ends the burst.
                        cnt   <= REC_LOAD;
                        state <= ST_RECOVER;
                    end else begin
                        beat <= 1'b1;
                        if (state == ST_READ) begin
                            hbus_valid <= 1'b1;
                            hbus_dat_o <= mem[ptr];
                        end else begin
                            hbus_ready <= 1'b1;
                        end
                    end
                end

                ST_RECOVER: begin
                    // Requests are ignored until the recovery period ends.
                    if (cnt == 8'd0) begin
                        hbus_busy <= 1'b0;
                        state     <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end

                default: begin
                    hbus_busy <= 1'b0;
                    beat      <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
